// File: rtl/rr_wrr_arbiter.sv
// rr_wrr_arbiter: round-robin arbiter with held grant and optional per-channel weighted turns
// Build option: define ARB_WRR_EN for weighted turns (credit counter); otherwise one transaction per turn.
// Ports: clk, rst (async, active-low); req_i per-channel level request; done_i completion pulse;
//   enable_i permits new grants; weight_i packed per-channel weights; grant_o one-hot grant;
//   grant_idx_o binary winner; grant_valid_o grant held; anyreq_o combinational OR of req_i.
module rr_wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 3,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic            done_i,
  input  logic            enable_i,
  input  logic [N*WW-1:0] weight_i,
  output logic [N-1:0]    grant_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            grant_valid_o,
  output logic            anyreq_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, nxt, arb_ptr, win;
  logic rel, start, more;
  assign anyreq_o = |req_i;
  assign nxt = (idx_q == IW'(N-1)) ? '0 : idx_q + 1'b1;
  // a releasing grant re-arbitrates from just past the winner in the same cycle
  assign arb_ptr = (state_q == GRANT) ? nxt : ptr_q;
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(arb_ptr) + k) % N]) win = IW'((int'(arb_ptr) + k) % N);
  end
  // a turn ends on the last credited done, or as soon as the winner withdraws its request
  assign rel   = (state_q == GRANT) && (!req_i[idx_q] || (done_i && !more));
  assign start = ((state_q == IDLE) || rel) && enable_i && anyreq_o;
`ifdef ARB_WRR_EN
  logic [WW-1:0] credit_q, credit_d, wsel, wload;
  assign wsel  = weight_i[win*WW +: WW];
  assign wload = (wsel == '0) ? WW'(1) : wsel;
  assign more  = credit_q > WW'(1);
  assign credit_d = start ? wload : (state_q == GRANT && done_i) ? credit_q - 1'b1 : credit_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) credit_q <= '0;
    else credit_q <= credit_d;
`else
  logic unused_weight;
  assign unused_weight = ^weight_i;
  assign more = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    state_d = start ? GRANT : rel ? IDLE : state_q;
    ptr_d   = rel ? nxt : ptr_q;
    idx_d   = start ? win : idx_q;
  end
  always_comb begin
    grant_valid_o = state_q == GRANT;
    grant_idx_o   = grant_valid_o ? idx_q : '0;
    grant_o       = grant_valid_o ? N'(1) << idx_q : '0;
  end
endmodule

// File: tb/tb_rr_wrr_arbiter.sv
// tb_rr_wrr_arbiter: directed bench with a behavioural arbitration model checked every cycle
module tb_rr_wrr_arbiter;
  localparam int N = 4, WW = 3, IW = 2;
  logic clk = 0, rst = 1, done = 0, enable = 1;
  logic [N-1:0] req = '0;
  logic [N*WW-1:0] weight = {4{3'd1}};
  logic [N-1:0] grant;
  logic [IW-1:0] grant_idx;
  logic grant_valid, anyreq;
  int checks = 0, errors = 0;
  int mg = -1, mptr = 0, mcred = 0;

  rr_wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk(clk), .rst(rst), .req_i(req), .done_i(done), .enable_i(enable), .weight_i(weight),
    .grant_o(grant), .grant_idx_o(grant_idx), .grant_valid_o(grant_valid), .anyreq_o(anyreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int wt(input int c, input logic [N*WW-1:0] w);
`ifdef ARB_WRR_EN
    int v;
    v = int'(w[c*WW +: WW]);
    return (v == 0) ? 1 : v;
`else
    return 1;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mg <= -1;
      mptr <= 0;
      mcred <= 0;
    end else begin
      automatic int g = mg, p = mptr, c = mcred;
      automatic bit r = 0;
      if (g < 0) begin
        if (enable && |req) begin
          g = pick(p, req);
          c = wt(g, weight);
        end
      end else begin
        if (!req[g]) r = 1;
        else if (done) begin
          c = c - 1;
          r = (c <= 0);
        end
        if (r) begin
          p = (g + 1) % N;
          if (enable && |req) begin
            g = pick(p, req);
            c = wt(g, weight);
          end else g = -1;
        end
      end
      mg <= g;
      mptr <= p;
      mcred <= c;
    end
  end

  always @(negedge clk) begin
    chk("model_grant", int'(grant), (mg < 0) ? 0 : (1 << mg));
    chk("model_idx", int'(grant_idx), (mg < 0) ? 0 : mg);
    chk("model_valid", int'(grant_valid), int'(mg >= 0));
    chk("model_anyreq", int'(anyreq), int'(|req));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string name, input logic [N-1:0] exp);
    chk(name, int'(grant), int'(exp));
  endtask

  task automatic do_reset();
    rst = 0;
    cyc();
    rst = 1;
  endtask

  logic [N-1:0] seq [4];

  initial begin
    #1 rst = 0;
    cyc(2);
    chk("reset_grant", int'(grant), 0);
    chk("reset_valid", int'(grant_valid), 0);
    chk("reset_idx", int'(grant_idx), 0);
    rst = 1;
    req = 4'b0100;
    cyc();
    lit("pre_reset_grant", 4'b0100);
    #2 rst = 0;
    #1;
    chk("async_rst_grant", int'(grant), 0);
    chk("async_rst_valid", int'(grant_valid), 0);
    chk("async_rst_idx", int'(grant_idx), 0);
    req = 4'b0001;
    cyc();
    rst = 1;
    cyc();
    lit("post_reset_grant", 4'b0001);
    req = '0;
    cyc();
    lit("post_reset_idle", 4'b0000);

    do_reset();
    req = 4'b1111;
    cyc();
    lit("rr_first", 4'b0001);
    done = 1;
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      cyc();
      lit("rr_step", seq[i]);
      chk("rr_valid", int'(grant_valid), 1);
    end
    done = 0;
    req = '0;
    cyc();
    lit("rr_idle", 4'b0000);

    do_reset();
    weight = {3'd3, 3'd1, 3'd1, 3'd1};
    req = 4'b1001;
    cyc();
    lit("wrr_first", 4'b0001);
    done = 1;
`ifdef ARB_WRR_EN
    seq = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
`else
    seq = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
`endif
    for (int i = 0; i < 4; i++) begin
      cyc();
      lit("wrr_step", seq[i]);
    end
    done = 0;
    req = '0;
    cyc();

    do_reset();
    req = 4'b1000;
    cyc();
    lit("early_first", 4'b1000);
    req = 4'b1001;
    done = 1;
    cyc();
`ifdef ARB_WRR_EN
    lit("early_after_done", 4'b1000);
`else
    lit("early_after_done", 4'b0001);
`endif
    done = 0;
    req = 4'b0001;
    cyc();
    lit("early_release", 4'b0001);
    req = 4'b1001;
    done = 1;
    cyc();
    lit("early_ptr_next", 4'b1000);
    done = 0;
    req = '0;
    cyc();

    do_reset();
    weight = {4{3'd1}};
    enable = 0;
    req = 4'b0010;
    cyc(2);
    lit("en_off_idle", 4'b0000);
    enable = 1;
    cyc();
    lit("en_on_grant", 4'b0010);
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      lit("en_off_hold", 4'b0010);
    end
    done = 1;
    cyc();
    lit("en_off_release", 4'b0000);
    done = 0;
    req = '0;
    enable = 1;
    cyc();

    do_reset();
    weight = '0;
    req = 4'b0011;
    cyc();
    lit("w0_first", 4'b0001);
    done = 1;
    cyc();
    lit("w0_second", 4'b0010);
    cyc();
    lit("w0_third", 4'b0001);
    done = 0;
    req = '0;
    cyc();

    do_reset();
    weight = {4{3'd1}};
    req = 4'b1000;
    cyc();
    lit("hold_first", 4'b1000);
    for (int i = 0; i < 10; i++) begin
      cyc();
      lit("hold_steady", 4'b1000);
    end
    req = 4'b1011;
    done = 1;
    cyc();
    lit("wrap_grant", 4'b0001);
    chk("wrap_idx", int'(grant_idx), 0);
    done = 0;
    req = '0;
    cyc();
    lit("final_idle", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_wrr_arbiter.md
# rr_wrr_arbiter

Parametrised round-robin arbiter with a registered, held grant. Each grant is held until the winner signals completion, and per-channel weights allow several back-to-back transactions per turn. It arbitrates N requesters for one shared resource, such as a memory port or writeback bus in the pipeline. It replaces free-running-pointer arbitration with a pointer that advances only past the last winner.

## Interface
- `N`, default 4: number of requesters; must be at least 2.
- `WW`, default 3: weight/credit width in bits.
- `IW`, default `$clog2(N)`: index width; derived, do not override.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  N  request per channel; level, held until served.
- `done`  in  1  one-cycle pulse: the current granted transaction has completed.
- `enable`  in  1  permits new grants; does not revoke a held grant.
- `weight`  in  N*WW  per-channel weight; channel i uses bits [i*WW +: WW].
- `grant`  out  N  registered one-hot grant.
- `grant_idx`  out  IW  binary index of the granted channel.
- `grant_valid`  out  1  a grant is held.
- `anyreq`  out  1  combinational OR of `req`.

## Operation
- Registered state:
  - `state`: IDLE or GRANT.
  - `pointer` (IW bits): highest-priority channel.
  - `credit` (WW bits): transactions remaining for the winner.
- Arbitration picks the first channel with `req` set, searching `pointer`, `pointer+1`, … with wrap modulo N.
- IDLE:
  - If `enable` and `anyreq`: register the winner's grant, load `credit` = `weight[winner]`, go to GRANT.
  - Otherwise stay in IDLE with all grant outputs 0.
- GRANT, `done` = 1:
  - Decrement `credit`.
  - If the post-decrement credit is greater than 0 and `req[winner]` = 1: keep the same grant (same turn).
  - Otherwise set `pointer` = winner+1 (N-1 wraps to 0) and re-arbitrate in the same cycle with the new pointer:
    - If `enable` and a request exists: register the new grant and reload credit; stay in GRANT.
    - Otherwise go to IDLE.
- GRANT, `req[winner]` drops without `done`: handled exactly as `done` with credit exhausted (pointer advances, re-arbitrate).
- GRANT, `done` = 0 and `req[winner]` = 1: hold the grant, credit and pointer. `enable` = 0 has no effect here.
- `done` in IDLE: ignored.
- A weight value of 0 is treated as 1.
- `weight` is sampled only when a fresh turn starts; changes during a turn take effect on the next turn.
- Invariants:
  - `grant` is always zero or one-hot.
  - `grant_valid` = |`grant`.
  - `grant_idx` = 0 whenever `grant_valid` = 0.
- Reset (`rst` = 0, asynchronous): state IDLE, `pointer` = 0, `credit` = 0, `grant` = 0, `grant_idx` = 0, `grant_valid` = 0. This applies immediately, including mid-turn.

## Timing
- Latency: a request sampled at edge k in IDLE (with `enable` = 1) gives a grant visible after edge k (1 cycle).
- Handover: `done` sampled at edge m gives the next grant after edge m. No bubble: `grant_valid` stays 1 if another request is pending.
- A held grant changes only at an edge where `done` = 1 or the winner's `req` is low.
- `anyreq` is purely combinational, with zero latency.
- Outputs follow no combinational path from `req`, `done` or `enable` except `anyreq`.

## Configuration
- `ARB_WRR_EN` defined:
  - Weighted round-robin as described.
  - Credit counter present.
- `ARB_WRR_EN` undefined:
  - Every turn is exactly one transaction: the pointer advances on every `done`.
  - The `weight` port remains but is ignored.
  - No credit register is built.

## Test plan
- **Reset:** drive `rst` = 0 mid-grant with `grant` = 0100 → `grant` = 0, `grant_valid` = 0, `grant_idx` = 0 immediately, without waiting for a clock edge. After release, `req` = 0001 → `grant` = 0001 one cycle later.
- **Plain round-robin:** all weights 1, `req` = 1111 held, `done` every cycle → grants 0001, 0010, 0100, 1000, 0001 with no idle cycles.
- **Weighted** (`ARB_WRR_EN`): `weight` = {3,1,1,1} (ch3 = 3), `req` = 1001 held, `done` every cycle → ch0, ch3, ch3, ch3, ch0. Without the macro → ch0, ch3, ch0, ch3.
- **Early release:** ch3 weight 3; ch3 drops `req` after one `done` → grant moves to ch0 the next cycle, and `pointer` = 0.
- **Enable:** with `enable` = 0 and `req` = 0010 in IDLE → no grant. With the grant held on ch1 and `enable` dropped → grant held until `done`, then IDLE.
- **Hold/wrap:** grant on ch3 with `done` = 0 for 10 cycles → grant unchanged. On `done` with `req` = 1011 → grant 0001 (pointer wraps to 0).
